// File: rtl/mips_multicycle.sv
// mips_multicycle: multi-cycle MIPS subset CPU with ready/valid instruction and data memory handshakes.
// Ports: clk/reset (async, active-high); instr_req/instr_addr/instr_in/instr_valid fetch handshake;
// data_req/data_we/data_addr/data_out/data_in/data_valid load/store handshake;
// retire pulses in the last cycle of each completed instruction; halt is a sticky trap flag.
module mips_multicycle #(
   parameter logic [31:0] PC_INIT     = 32'h0,
   parameter logic [31:0] SP_INIT     = 32'h0,
   parameter logic [31:0] RA_INIT     = 32'h0,
   parameter logic        ALIGN_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   output logic        instr_req,
   output logic [31:0] instr_addr,
   input  logic [31:0] instr_in,
   input  logic        instr_valid,
   output logic        data_req,
   output logic        data_we,
   output logic [31:0] data_addr,
   output logic [31:0] data_out,
   input  logic [31:0] data_in,
   input  logic        data_valid,
   output logic        retire,
   output logic        halt
);
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
   state_t state, state_nx;
   logic [31:0] rf [32];
   logic [31:0] pc, pc4, ir, res;
   logic [31:0] ra, rb, sext, opb, alu, maddr, br_pc, j_pc, jr_pc, npc;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, wa;
   logic        is_r, is_nop, is_jr, is_br, is_j, is_jal, is_sw, is_mem, legal, mis_mem, mis_jr, taken;

   assign op     = ir[31:26];
   assign rs     = ir[25:21];
   assign rt     = ir[20:16];
   assign rd     = ir[15:11];
   assign funct  = ir[5:0];
   assign ra     = rf[rs];
   assign rb     = rf[rt];
   assign sext   = {{16{ir[15]}}, ir[15:0]};
   assign is_r   = op == 6'h00;
   assign is_nop = ir == 32'd0;
   assign is_jr  = is_r && funct == 6'h08;
   assign is_br  = op == 6'h04 || op == 6'h05;
   assign is_j   = op == 6'h02 || op == 6'h03;
   assign is_jal = op == 6'h03;
   assign is_sw  = op == 6'h2B;
   assign is_mem = op == 6'h23 || is_sw;
   // Only sll with every field zero (the canonical NOP) is accepted among shifts.
   assign legal  = is_r ? (is_nop || funct inside {6'h08, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2A})
                        : op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
   assign opb    = is_r ? rb : (op == 6'h0C || op == 6'h0D) ? {16'd0, ir[15:0]} : sext;
   assign alu    = (is_r && funct == 6'h23) ? ra - rb :
                   (is_r ? funct == 6'h24 : op == 6'h0C) ? ra & opb :
                   (is_r ? funct == 6'h25 : op == 6'h0D) ? ra | opb :
                   (is_r && funct == 6'h2A) ? {31'd0, $signed(ra) < $signed(rb)} :
                   (op == 6'h0F) ? {ir[15:0], 16'd0} : ra + opb;
   assign mis_mem = ALIGN_CHECK && alu[1:0] != 2'b00;
   assign mis_jr  = ALIGN_CHECK && ra[1:0] != 2'b00;
   assign maddr   = {alu[31:2], ALIGN_CHECK ? alu[1:0] : 2'b00};
   assign taken   = (ra == rb) ^ (op == 6'h05);
   assign br_pc   = pc4 + {sext[29:0], 2'b00};
   assign j_pc    = {pc4[31:28], ir[25:0], 2'b00};
   assign jr_pc   = {ra[31:2], 2'b00};
   assign npc     = is_br ? (taken ? br_pc : pc4) : is_j ? j_pc : is_jr ? jr_pc : pc4;
   assign wa      = is_jal ? 5'd31 : is_r ? rd : rt;

   // The reset term keeps the fetch request low while reset is held, since FETCH is the reset state.
   assign instr_req  = state == FETCH && !reset;
   assign instr_addr = pc;
   assign data_req   = state == MEM;
   assign data_we    = state == MEM && is_sw;
   assign data_addr  = res;
   assign data_out   = rb;
   assign halt       = state == TRAP;
   assign retire     = (state == EXEC && (is_br || op == 6'h02 || is_nop || (is_jr && !mis_jr))) ||
                       (state == MEM && is_sw && data_valid) || state == WB;

   always_comb begin
      state_nx = state;
      case (state)
         FETCH:   state_nx = instr_valid ? DECODE : FETCH;
         DECODE:  state_nx = legal ? EXEC : TRAP;
         EXEC:    state_nx = is_mem ? (mis_mem ? TRAP : MEM) : (is_jr && mis_jr) ? TRAP : retire ? FETCH : WB;
         MEM:     state_nx = !data_valid ? MEM : is_sw ? FETCH : WB;
         WB:      state_nx = FETCH;
         default: state_nx = TRAP;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         pc    <= PC_INIT;
         pc4   <= 32'd0;
         ir    <= 32'd0;
         res   <= 32'd0;
         for (int i = 0; i < 32; i++) rf[i] <= (i == 29) ? SP_INIT : (i == 31) ? RA_INIT : 32'd0;
      end else begin
         state <= state_nx;
         if (state == FETCH && instr_valid) begin
            ir  <= instr_in;
            pc4 <= pc + 32'd4;
         end
         // res carries the memory address, ALU result, link address or loaded word into WB.
         if (state == EXEC) res <= is_jal ? pc4 : is_mem ? maddr : alu;
         if (state == MEM && data_valid && !is_sw) res <= data_in;
         if (retire) pc <= (state == EXEC) ? npc : is_jal ? j_pc : pc4;
         if (state == WB && wa != 5'd0) rf[wa] <= res;
      end
   end
endmodule
